inst_prefetch_buf: RTL and testbench

Parametrised instruction prefetch unit between the CPU fetch stage and the instruction bus. It replaces the single-word fetch-and-latch scheme with a DEPTH-entry prefetch FIFO, which fetches sequential words ahead of the pipeline while the FIFO has room. It keeps at most one bus request outstanding and supports pipeline redirection (flush to a new PC) at any time, including while a response is pending.

---
 rtl/inst_prefetch_buf_pkg.sv | 20 ++
 rtl/inst_prefetch_buf_fifo.sv | 68 ++++++
 rtl/inst_prefetch_buf.sv | 98 +++++++++
 tb/tb_inst_prefetch_buf.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds the fetch FSM encoding, the FIFO entry width and the PC increment helper.
package inst_prefetch_buf_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDrop = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // FIFO entry layout: {pc[31:2], instruction}
   localparam int unsigned EntryW = 62;

   function automatic logic [29:0] pc_incr(input logic [29:0] pc);
      return pc + 30'd1;
   endfunction

endpackage

// File: rtl/inst_prefetch_buf_fifo.sv
// DEPTH-entry FIFO with synchronous write and asynchronous head read.
// A clear overrides any push or pop in the same cycle.
module inst_fifo
   import inst_prefetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [EntryW-1:0]        wdata_i,
   output logic [EntryW-1:0]        head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [EntryW-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   always_comb begin
      do_push  = push_i & ~clear_i & (count_q != FullCount);
      do_pop   = pop_i & ~clear_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      count_d = count_q + (AW + 1)'(1);
         else if (!do_push && do_pop) count_d = count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch unit: keeps a DEPTH-entry FIFO of sequential words filled
// from the instruction bus with one request in flight, and supports redirect at any time.
module inst_prefetch_buf
   import inst_prefetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        flush,
   input  logic [29:0] flush_pc,
   input  logic        inst_take,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [29:0] inst_pc,
   output logic        imr_run,
   output logic        i_read_req,
   output logic        i_read_w,
   output logic        i_read_hw,
   output logic [31:0] i_read_adr,
   input  logic        i_read_valid,
   input  logic [31:0] i_read_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW+1:0] CreditLimit = (AW + 2)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [29:0]       fetch_pc_q, fetch_pc_d;
   logic [AW:0]       count;
   logic [EntryW-1:0] head;
   logic [AW+1:0]     credit_used;
   logic              outstanding;
   logic              push, pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         fetch_pc_q <= RESET_PC[31:2];
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (i_read_req) state_d = StWait;
         StWait: begin
            if (flush)             state_d = i_read_valid ? StIdle : StDrop;
            else if (i_read_valid) state_d = StIdle;
         end
         StDrop: if (i_read_valid) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Every request reserves a slot, so an accepted response can never overflow.
   always_comb begin
      outstanding = (state_q != StIdle);
      credit_used = {1'b0, count} + {{(AW + 1){1'b0}}, outstanding};
      i_read_req  = 1'b0;
      if (state_q == StIdle) i_read_req = fetch_en & ~flush & (credit_used < CreditLimit);
      imr_run     = i_read_req | outstanding;
   end

   always_comb begin
      push       = (state_q == StWait) & i_read_valid & ~flush;
      pop        = inst_take & inst_valid & ~flush;
      fetch_pc_d = fetch_pc_q;
      if (flush)     fetch_pc_d = flush_pc;
      else if (push) fetch_pc_d = pc_incr(fetch_pc_q);
   end

   inst_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({fetch_pc_q, i_read_data}),
      .head_o  (head),
      .count_o (count)
   );

   assign inst_valid = (count != '0);
   assign inst       = head[31:0];
   assign inst_pc    = head[61:32];
   assign i_read_w   = 1'b1;
   assign i_read_hw  = 1'b0;
   assign i_read_adr = {fetch_pc_q, 2'b00};

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Scoreboard bench for inst_prefetch_buf: directed scenarios push expected bus
// addresses and instructions; a negedge monitor checks requests and consumed entries.
module tb_inst_prefetch_buf;

   localparam int BusLat = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        flush = 1'b0;
   logic [29:0] flush_pc = '0;
   logic        inst_take = 1'b0;
   logic        i_read_valid = 1'b0;
   logic [31:0] i_read_data = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [29:0] inst_pc;
   logic        imr_run;
   logic        i_read_req;
   logic        i_read_w;
   logic        i_read_hw;
   logic [31:0] i_read_adr;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_req[$];
   logic [61:0] exp_inst[$];

   inst_prefetch_buf #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fetch_en     (fetch_en),
      .flush        (flush),
      .flush_pc     (flush_pc),
      .inst_take    (inst_take),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .imr_run      (imr_run),
      .i_read_req   (i_read_req),
      .i_read_w     (i_read_w),
      .i_read_hw    (i_read_hw),
      .i_read_adr   (i_read_adr),
      .i_read_valid (i_read_valid),
      .i_read_data  (i_read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bus_data(input logic [31:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   function automatic logic [61:0] entry(input logic [31:0] adr);
      return {adr[31:2], bus_data(adr)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i_read_req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_bus_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i_read_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_inst_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (inst_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Bus responder: answers each request BusLat cycles later, optional data override.
   int          bus_cnt = 0;
   logic [31:0] bus_adr = '0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = '0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && i_read_req) begin
            bus_cnt = BusLat;
            bus_adr = i_read_adr;
         end
         @(posedge clk);
         #1;
         i_read_valid = 1'b0;
         if (bus_cnt > 0) begin
            bus_cnt--;
            if (bus_cnt == 0) begin
               i_read_valid = 1'b1;
               i_read_data  = ovr_en ? ovr_data : bus_data(bus_adr);
               ovr_en       = 1'b0;
            end
         end
      end
   end

   // Monitor: every request and every consumed entry is checked against the queues.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (i_read_req) begin
            check("req_not_back_to_back", {63'd0, prev_req}, 64'd0);
            if (exp_req.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_req: got adr %0h, want no request", i_read_adr);
            end else begin
               check("req_adr", {32'd0, i_read_adr}, {32'd0, exp_req.pop_front()});
            end
         end
         if (inst_take && inst_valid && !flush) begin
            if (exp_inst.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_inst: got pc %0h, want nothing", inst_pc);
            end else begin
               check("inst_entry", {2'b0, inst_pc, inst}, {2'b0, exp_inst.pop_front()});
            end
         end
         prev_req <= i_read_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
      check("rst_inst", {32'd0, inst}, 64'd0);
      check("rst_inst_pc", {34'd0, inst_pc}, 64'd0);
      check("rst_req", {63'd0, i_read_req}, 64'd0);
      check("rst_imr_run", {63'd0, imr_run}, 64'd0);
      check("rd_w_hw", {62'd0, i_read_w, i_read_hw}, 64'd2);
      next_cyc();
      rst_n = 1'b1;

      // Fill from reset: four sequential requests, then stop on credits
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      next_cyc();
      fetch_en = 1'b1;
      wait_bus_valid(ok);
      check("s1_first_resp", {63'd0, ok}, 64'd1);
      check("s1_not_valid_yet", {63'd0, inst_valid}, 64'd0);
      next_cyc();
      @(negedge clk);
      check("s1_inst_valid", {63'd0, inst_valid}, 64'd1);
      check("s1_inst_pc", {34'd0, inst_pc}, 64'd0);
      check("s1_inst", {32'd0, inst}, {32'd0, bus_data(32'h0)});
      repeat (20) next_cyc();
      check("s1_reqs_done", exp_req.size(), 64'd0);

      // Full FIFO, one take frees one credit
      for (int i = 0; i < 4; i++) exp_inst.push_back(entry(32'(i * 4)));
      exp_req.push_back(32'h10);
      next_cyc();
      inst_take = 1'b1;
      next_cyc();
      inst_take = 1'b0;
      repeat (10) next_cyc();
      check("s2_one_req", exp_req.size(), 64'd0);

      // Flush while WAIT, response arrives one cycle later and is dropped
      exp_req.push_back(32'h14);
      next_cyc();
      inst_take = 1'b1;
      next_cyc();
      inst_take = 1'b0;
      wait_req(ok);
      check("s3_req_seen", {63'd0, ok}, 64'd1);
      exp_inst.delete();
      exp_req.push_back(32'h100);
      next_cyc();
      flush    = 1'b1;
      flush_pc = 30'h40;
      ovr_en   = 1'b1;
      ovr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("s3_wait_imr_run", {62'd0, imr_run, i_read_req}, 64'd2);
      next_cyc();
      flush = 1'b0;
      @(negedge clk);
      check("s3_flushed_empty", {63'd0, inst_valid}, 64'd0);
      check("s3_resp_arrived", {63'd0, i_read_valid}, 64'd1);
      next_cyc();
      @(negedge clk);
      check("s3_drop_not_pushed", {63'd0, inst_valid}, 64'd0);
      check("s3_redirect_req", {63'd0, i_read_req}, 64'd1);
      exp_req.push_back(32'h104);
      exp_req.push_back(32'h108);
      exp_req.push_back(32'h10C);
      for (int i = 0; i < 4; i++) exp_inst.push_back(entry(32'h100 + 32'(i * 4)));
      wait_inst_valid(ok);
      check("s3_valid_after_redirect", {63'd0, ok}, 64'd1);
      check("s3_first_pc", {34'd0, inst_pc}, 64'h40);
      check("s3_first_inst", {32'd0, inst}, {32'd0, bus_data(32'h100)});
      repeat (20) next_cyc();
      fetch_en = 1'b0;

      // Push and take in the same cycle with two entries held
      inst_take = 1'b1;
      next_cyc();
      next_cyc();
      inst_take = 1'b0;
      exp_req.push_back(32'h110);
      exp_inst.push_back(entry(32'h110));
      next_cyc();
      fetch_en = 1'b1;
      wait_req(ok);
      check("s5_req_seen", {63'd0, ok}, 64'd1);
      next_cyc();
      fetch_en = 1'b0;
      next_cyc();
      inst_take = 1'b1;
      @(negedge clk);
      check("s5_push_take_aligned", {63'd0, i_read_valid}, 64'd1);
      next_cyc();
      inst_take = 1'b0;
      @(negedge clk);
      check("s5_head_after", {33'd0, inst_valid, inst_pc}, {33'd0, 1'b1, 30'h43});
      next_cyc();
      inst_take = 1'b1;
      next_cyc();
      next_cyc();
      next_cyc();
      inst_take = 1'b0;
      @(negedge clk);
      check("s5_drained", {63'd0, inst_valid}, 64'd0);

      // Flush in the same cycle as the response
      exp_req.push_back(32'h114);
      exp_req.push_back(32'h200);
      next_cyc();
      fetch_en = 1'b1;
      wait_req(ok);
      check("s4_req_seen", {63'd0, ok}, 64'd1);
      next_cyc();
      next_cyc();
      flush    = 1'b1;
      flush_pc = 30'h80;
      @(negedge clk);
      check("s4_valid_with_flush", {63'd0, i_read_valid}, 64'd1);
      next_cyc();
      flush = 1'b0;
      @(negedge clk);
      check("s4_req_next_cycle", {31'd0, i_read_req, i_read_adr}, {31'd0, 1'b1, 32'h200});
      check("s4_discarded", {63'd0, inst_valid}, 64'd0);
      next_cyc();
      fetch_en = 1'b0;
      exp_inst.push_back(entry(32'h200));
      wait_inst_valid(ok);
      check("s4_valid", {63'd0, ok}, 64'd1);
      next_cyc();
      inst_take = 1'b1;
      next_cyc();
      inst_take = 1'b0;

      // PC wrap at the top of the address space
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0);
      exp_inst.push_back(entry(32'hFFFF_FFFC));
      exp_inst.push_back(entry(32'h0));
      next_cyc();
      flush    = 1'b1;
      flush_pc = 30'h3FFF_FFFF;
      fetch_en = 1'b1;
      @(negedge clk);
      check("s6_no_req_in_flush", {63'd0, i_read_req}, 64'd0);
      next_cyc();
      flush = 1'b0;
      wait_req(ok);
      check("s6_req_top", {63'd0, ok}, 64'd1);
      wait_req(ok);
      check("s6_req_wrap", {63'd0, ok}, 64'd1);
      check("s6_wrap_adr", {32'd0, i_read_adr}, 64'd0);
      next_cyc();
      fetch_en = 1'b0;
      repeat (4) next_cyc();
      inst_take = 1'b1;
      next_cyc();
      next_cyc();
      inst_take = 1'b0;
      @(negedge clk);
      check("end_empty", {63'd0, inst_valid}, 64'd0);
      check("end_idle", {63'd0, imr_run}, 64'd0);
      check("end_req_queue", exp_req.size(), 64'd0);
      check("end_inst_queue", exp_inst.size(), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
